radix8_mul_sequencer: RTL and testbench

RADIX8_MUL_SEQUENCER -- requirements
Module: radix8_mul_sequencer

---
 rtl/radix8_mul_sequencer_pkg.sv | 56 +++++
 rtl/radix8_mul_sequencer_preprocess.sv | 49 ++++
 rtl/radix8_mul_sequencer.sv | 133 +++++++++++++
 tb/tb_radix8_mul_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix8_mul_sequencer_pkg.sv
// Shared types and constants for the radix-8 sequential multiplier.
// Holds the FSM state enum, digit geometry and the multiple-select encoding.
package radix8_mul_sequencer_pkg;

    localparam int DIGIT_W = 3;
    localparam int DIGIT_N = 3;
    localparam int MAG_W   = 7;
    localparam int MULT_W  = 10;
    localparam int ACC_W   = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACC0,
        ST_ACC1,
        ST_ACC2,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_1X,
        SEL_2X,
        SEL_3X,
        SEL_4X,
        SEL_5X,
        SEL_6X,
        SEL_7X
    } sel_t;

    typedef struct packed {
        logic              neg;
        logic [MULT_W-1:0] x1;
        logic [MULT_W-1:0] x3;
        logic [MULT_W-1:0] x5;
        logic [MULT_W-1:0] x7;
    } mult_t;

    // Even multiples are shifts of the odd precomputed ones.
    function automatic logic [MULT_W-1:0] pick(sel_t s, mult_t mu);
        logic [MULT_W-1:0] r;
        r = '0;
        unique case (s)
            SEL_ZERO: r = '0;
            SEL_1X:   r = mu.x1;
            SEL_2X:   r = mu.x1 << 1;
            SEL_3X:   r = mu.x3;
            SEL_4X:   r = mu.x1 << 2;
            SEL_5X:   r = mu.x5;
            SEL_6X:   r = mu.x3 << 1;
            SEL_7X:   r = mu.x7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/radix8_mul_sequencer_preprocess.sv
// PreprocessUnit: captures |mcand| and its sign on iEn, then registers 1X/3X/5X/7X.
// Ports: clk, rst (async high), iEn, iMcand[7:0], oMult[OUTPUT_PORT_NUM] (multiples + neg).
module PreprocessUnit
    import radix8_mul_sequencer_pkg::*;
#(
    parameter int OUTPUT_PORT_NUM = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iEn,
    input  logic [7:0]                  iMcand,
    output mult_t [OUTPUT_PORT_NUM-1:0] oMult
);

    logic [MAG_W-1:0]  mag_q;
    logic              neg_q;
    logic [MULT_W-1:0] base;
    mult_t             m_nx;

    // -128 wraps to 0 here; the sequencer forces that product to 0 anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            neg_q <= 1'b0;
        end else if (iEn) begin
            mag_q <= iMcand[7] ? MAG_W'(-iMcand) : iMcand[MAG_W-1:0];
            neg_q <= iMcand[7];
        end
    end

    assign base = MULT_W'(mag_q);

    assign m_nx = '{
        neg: neg_q,
        x1:  base,
        x3:  base + (base << 1),
        x5:  base + (base << 2),
        x7:  (base << 3) - base
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oMult <= '0;
        end else begin
            oMult <= {OUTPUT_PORT_NUM{m_nx}};
        end
    end

endmodule

// File: rtl/radix8_mul_sequencer.sv
// Radix-8 sequential 8x8 signed multiplier: one 3-bit multiplier digit per ACC cycle.
// Ports: clk, rst (async high), iValid/oReady (operand handshake), iMcand, iMplier,
//        oValid/iReady (result handshake), oProduct[PRODUCT_W], oRangeErr (-128 seen), oBusy.
// Macro EARLY_TERM_EN: skip ACC states whose remaining multiplier digits are zero.
module radix8_mul_sequencer
    import radix8_mul_sequencer_pkg::*;
#(
    parameter int PRODUCT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [7:0]           iMcand,
    input  logic [7:0]           iMplier,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [PRODUCT_W-1:0] oProduct,
    output logic                 oRangeErr,
    output logic                 oBusy
);

    state_t                 state_q;
    logic [MAG_W-1:0]       m_q;
    logic                   sign_q;
    logic                   rerr_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_nx;
    logic [ACC_W-1:0]       addend;
    logic [DIGIT_W-1:0]     digit;
    logic [3:0]             shift;
    mult_t [0:0]            mult;
    logic                   accept;
    logic                   last;
    logic signed [15:0]     mag16;
    logic signed [15:0]     res16;
    logic signed [PRODUCT_W-1:0] res_w;

    assign oReady = (state_q == ST_IDLE) | ((state_q == ST_DONE) & iReady);
    assign accept = iValid & oReady;
    assign oBusy  = (state_q != ST_IDLE);

    PreprocessUnit #(
        .OUTPUT_PORT_NUM(1)
    ) u_pre (
        .clk    (clk),
        .rst    (rst),
        .iEn    (accept),
        .iMcand (iMcand),
        .oMult  (mult)
    );

    always_comb begin
        digit = '0;
        shift = '0;
        unique case (1'b1)
            state_q == ST_ACC0: begin
                digit = m_q[2:0];
            end
            state_q == ST_ACC1: begin
                digit = m_q[5:3];
                shift = 4'(DIGIT_W);
            end
            state_q == ST_ACC2: begin
                digit = {2'b00, m_q[6]};
                shift = 4'(2 * DIGIT_W);
            end
            default: ;
        endcase
    end

    assign addend = ACC_W'(pick(sel_t'(digit), mult[0])) << shift;
    assign acc_nx = acc_q + addend;

`ifdef EARLY_TERM_EN
    assign last = (state_q == ST_ACC2)
                | ((state_q == ST_ACC0) & (m_q[6:3] == 4'd0))
                | ((state_q == ST_ACC1) & ~m_q[6]);
`else
    assign last = (state_q == ST_ACC2);
`endif

    // Magnitude is at most 127*127, so the 16-bit negate cannot overflow.
    assign mag16 = signed'({1'b0, acc_nx});
    assign res16 = (mult[0].neg ^ sign_q) ? -mag16 : mag16;
    assign res_w = res16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            sign_q    <= 1'b0;
            rerr_q    <= 1'b0;
            acc_q     <= '0;
            oValid    <= 1'b0;
            oProduct  <= '0;
            oRangeErr <= 1'b0;
        end else if (accept) begin
            state_q <= ST_LOAD;
            m_q     <= iMplier[7] ? MAG_W'(-iMplier) : iMplier[MAG_W-1:0];
            sign_q  <= iMplier[7];
            rerr_q  <= (iMcand == 8'h80) | (iMplier == 8'h80);
            acc_q   <= '0;
            oValid  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_LOAD: state_q <= ST_ACC0;
                ST_ACC0, ST_ACC1, ST_ACC2: begin
                    acc_q <= acc_nx;
                    if (last) begin
                        state_q   <= ST_DONE;
                        oValid    <= 1'b1;
                        oProduct  <= rerr_q ? '0 : PRODUCT_W'(res_w);
                        oRangeErr <= rerr_q;
                    end else if (state_q == ST_ACC0) begin
                        state_q <= ST_ACC1;
                    end else begin
                        state_q <= ST_ACC2;
                    end
                end
                ST_DONE: begin
                    if (iReady) begin
                        state_q <= ST_IDLE;
                        oValid  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix8_mul_sequencer.sv
// Self-checking bench for radix8_mul_sequencer: directed cases plus random
// handshake traffic compared every cycle against a transaction-level model.
module tb_radix8_mul_sequencer;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iValid = 1'b0;
    logic          iReady = 1'b0;
    logic [7:0]    iMcand = '0;
    logic [7:0]    iMplier = '0;
    logic          oReady;
    logic          oValid;
    logic          oRangeErr;
    logic          oBusy;
    logic [PW-1:0] oProduct;

    int checks = 0;
    int failures = 0;

    radix8_mul_sequencer #(.PRODUCT_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iMcand    (iMcand),
        .iMplier   (iMplier),
        .oValid    (oValid),
        .iReady    (iReady),
        .oProduct  (oProduct),
        .oRangeErr (oRangeErr),
        .oBusy     (oBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Product from plain integer arithmetic; -128 on either side yields 0.
    function automatic logic [PW-1:0] ref_mul(input logic [7:0] a,
                                              input logic [7:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (a == 8'h80 || b == 8'h80) return '0;
        return PW'(sa * sb);
    endfunction

    // Edges from accept to result, not counting the accept edge itself.
    function automatic int lat_of(input logic [7:0] b);
        int sb;
        int m;
        sb = $signed(b);
        m = (sb < 0 ? -sb : sb) % 128;
`ifdef EARLY_TERM_EN
        if (m < 8) return 2;
        if (m < 64) return 3;
`endif
        if (m < 0) return 0;
        return 4;
    endfunction

    // Transaction-level model: busy from accept until handoff, valid after latency.
    bit            m_busy = 1'b0;
    bit            m_valid = 1'b0;
    int            m_cnt = 0;
    int            m_lat = 4;
    logic [PW-1:0] m_prod = '0;
    bit            m_err = 1'b0;
    logic          m_ready;

    assign m_ready = !m_busy || (m_valid && iReady);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (iValid && m_ready) begin
            m_busy  <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_lat   <= lat_of(iMplier);
            m_prod  <= ref_mul(iMcand, iMplier);
            m_err   <= (iMcand == 8'h80) || (iMplier == 8'h80);
        end else if (m_valid && iReady) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_busy && !m_valid) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) m_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_valid", oValid, m_valid);
            chk("cyc_busy", oBusy, m_busy);
            chk("cyc_ready", oReady, m_ready);
            if (m_valid) begin
                chk("cyc_product", oProduct, m_prod);
                chk("cyc_rangeerr", oRangeErr, m_err);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        iMcand = a;
        iMplier = b;
        iValid = 1'b1;
        while (!oReady && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ready_wait", oReady, 1'b1);
        @(posedge clk);
        #1;
        iValid = 1'b0;
        iMcand = 8'($urandom);
        iMplier = 8'($urandom);
    endtask

    // Edge count includes the accept edge as edge 1.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!oValid && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("result_arrives", oValid, 1'b1);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         output int edges);
        accept_op(a, b);
        wait_valid(edges);
    endtask

    initial begin
        int e;
        logic [PW-1:0] held;
        int r;

        chk("model_127x127", ref_mul(8'd127, 8'd127), 16'd16129);
        chk("model_m5x3", ref_mul(8'hFB, 8'd3), 16'hFFF1);
        chk("model_m7xm9", ref_mul(8'hF9, 8'hF7), 16'd63);
        chk("model_m128", ref_mul(8'h80, 8'd2), 16'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", oValid, 1'b0);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_ready", oReady, 1'b1);
        chk("rst_product", oProduct, 16'd0);
        chk("rst_rangeerr", oRangeErr, 1'b0);
        rst = 1'b0;
        iReady = 1'b1;
        @(posedge clk);
        #1;

        issue(8'd127, 8'd127, e);
        chk("lat_full", e, 5);
        chk("p_127x127", oProduct, 16'd16129);
        chk("e_127x127", oRangeErr, 1'b0);

        issue(8'hFB, 8'd3, e);
        chk("p_m5x3", oProduct, 16'hFFF1);

        issue(8'hF9, 8'hF7, e);
        chk("p_m7xm9", oProduct, 16'd63);

        issue(8'h80, 8'd2, e);
        chk("p_m128", oProduct, 16'd0);
        chk("e_m128", oRangeErr, 1'b1);
        issue(8'd3, 8'd4, e);
        chk("p_3x4", oProduct, 16'd12);
        chk("e_3x4", oRangeErr, 1'b0);

        issue(8'd0, 8'hFB, e);
        chk("p_0xm5", oProduct, 16'd0);
        issue(8'hF7, 8'd0, e);
        chk("p_m9x0", oProduct, 16'd0);

        @(posedge clk);
        #1;
        iReady = 1'b0;
        issue(8'd10, 8'hF5, e);
        held = oProduct;
        chk("p_10xm11", held, 16'hFF92);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("hold_product", oProduct, 16'hFF92);
            chk("hold_ready", oReady, 1'b0);
            chk("hold_valid", oValid, 1'b1);
        end
        iReady = 1'b1;
        iMcand = 8'd6;
        iMplier = 8'd7;
        iValid = 1'b1;
        #1;
        chk("handoff_ready", oReady, 1'b1);
        @(posedge clk);
        #1;
        iValid = 1'b0;
        chk("handoff_valid", oValid, 1'b0);
        chk("handoff_busy", oBusy, 1'b1);
        wait_valid(e);
        chk("p_6x7", oProduct, 16'd42);

`ifdef EARLY_TERM_EN
        issue(8'd9, 8'd5, e);
        chk("et_lat_small", e, 3);
        chk("et_p_9x5", oProduct, 16'd45);
        issue(8'd9, 8'd20, e);
        chk("et_lat_mid", e, 4);
        chk("et_p_9x20", oProduct, 16'd180);
        issue(8'd9, 8'd0, e);
        chk("et_p_9x0", oProduct, 16'd0);
`endif

        accept_op(8'd2, 8'd100);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", oBusy, 1'b0);
        chk("midrst_valid", oValid, 1'b0);
        chk("midrst_ready", oReady, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("midrst_noresult", oValid, 1'b0);
        end
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        issue(8'd2, 8'd3, e);
        chk("p_2x3", oProduct, 16'd6);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            iValid = ($urandom_range(0, 2) != 0);
            iReady = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            iMcand = (r == 0) ? 8'h80 : (r == 1) ? 8'h00 : 8'($urandom);
            r = $urandom_range(0, 9);
            iMplier = (r == 0) ? 8'h80 : (r == 1) ? 8'h00 :
                      (r == 2) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        end
        iValid = 1'b0;
        iReady = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
